// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg
//   Shared constants and helpers for the dff_pipe register pipeline.
//   DFF_PIPE_MAX_DEPTH : deepest pipeline the block is meant to be built with.
//   occ_width(depth)   : bit width needed to count 0..depth held words.
package dff_pipe_pkg;

  localparam int DFF_PIPE_MAX_DEPTH = 16;

  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage
//   One {valid, data} register of the dff_pipe pipeline.
//   Ports:
//     clk        clock, updates on posedge
//     rst        asynchronous active-low reset (valid=0, data=RST_VAL)
//     load       capture src_valid/src_data this cycle
//     clear      synchronous clear (valid=0, data=RST_VAL); wins over load
//     src_valid  valid bit from the previous stage (or pipeline input)
//     src_data   word from the previous stage (or pipeline input)
//     valid      registered valid bit
//     data       registered word
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= RST_VAL;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= RST_VAL;
    end else if (load) begin
      valid <= src_valid;
      data  <= src_data;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe
//   DEPTH-stage register pipeline of WIDTH-bit words with valid/ready flow
//   control, bubble collapsing, a global stall (en) and a synchronous flush.
//   Optional feature: define DFF_PIPE_OCC_EN to add the occ port (number of
//   words currently held, 0..DEPTH). Without it the port and logic are absent.
//   Ports:
//     clk        clock, all state updates on posedge
//     rst        asynchronous active-low reset
//     en         global enable; 0 freezes every stage
//     flush      synchronous clear of every stage (priority over en)
//     in_valid   upstream word valid
//     in_ready   pipeline accepts a word this cycle
//     in_data    upstream word
//     out_valid  last stage holds a word
//     out_ready  downstream accepts this cycle
//     out_data   last-stage word
//     occ        words held (only with DFF_PIPE_OCC_EN)
//
//   Handshake: a word moves across an interface in a cycle where valid and
//   ready are both 1 at the rising edge. in_ready never depends on in_valid;
//   out_valid/out_data are register outputs and stay stable while
//   out_valid=1 and out_ready=0.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  // Stage count held inside the supported range.
  localparam int NSTAGE = (DEPTH < 1) ? 1 :
                          ((DEPTH > DFF_PIPE_MAX_DEPTH) ? DFF_PIPE_MAX_DEPTH : DEPTH);

  logic [NSTAGE-1:0] v;
  logic [NSTAGE-1:0] rdy;
  logic [WIDTH-1:0]  d [NSTAGE];
  logic              advance;
  logic              chain;

  // Ready ripples from the output back to the input: a stage can take a new
  // word if it is empty or if its own word moves on this cycle. An empty
  // stage is always ready, which is what squeezes bubbles out under stall.
  always_comb begin
    chain = out_ready;
    rdy   = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      chain  = ~v[k] | chain;
      rdy[k] = chain;
    end
  end

  assign advance = en & ~flush;
  // rst gates in_ready so nothing is reported as accepted while in reset.
  assign in_ready = rst & advance & rdy[0];

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;

    if (k == 0) begin : g_src_in
      assign src_v = in_valid;
      assign src_d = in_data;
    end else begin : g_src_prev
      assign src_v = v[k-1];
      assign src_d = d[k-1];
    end

    dff_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .load      (advance & rdy[k]),
      .clear     (flush),
      .src_valid (src_v),
      .src_data  (src_d),
      .valid     (v[k]),
      .data      (d[k])
    );
  end

  assign out_valid = v[NSTAGE-1];
  assign out_data  = d[NSTAGE-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int OW = occ_width(DEPTH);

  // Popcount of the registered valid bits, so it tracks state exactly and
  // reads 0 after reset or flush.
  always_comb begin
    occ = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      occ = occ + OW'(v[k]);
    end
  end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe
//   Self-checking bench for dff_pipe (WIDTH=8, DEPTH=3). The reference model
//   tracks each held word as a slot position plus an ordered queue of the
//   expected data; define DFF_PIPE_OCC_EN to also check the occ port.
module tb_dff_pipe;
  import dff_pipe_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int OW    = occ_width(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef DFF_PIPE_OCC_EN
  logic [OW-1:0]    occ;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: pos_q[i] is the stage slot of the i-th oldest word,
  // exp_q[i] its data.
  int               pos_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];

  logic             seen_ir;
  logic             seen_ov;
  logic [WIDTH-1:0] seen_od;
  logic             last_acc;

  always #5 clk = ~clk;

  dff_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL ('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DFF_PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  // Drives one clock cycle, checks the DUT's combinational/registered view
  // against the model, then advances the model across the edge.
  task automatic do_cycle(input logic iv, input logic [WIDTH-1:0] id,
                          input logic ordy, input logic e, input logic fl);
    logic exp_ir, exp_ov, pop, acc;
    int   cnt, lim, np;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    en        = e;
    flush     = fl;
    #1;
    cnt    = pos_q.size();
    exp_ov = (cnt > 0) && (pos_q[0] == DEPTH - 1);
    // A slot is free somewhere, or the full pipe pops this cycle.
    exp_ir = e && !fl && ((cnt < DEPTH) || (exp_ov && ordy));
    n_checks++;
    if (in_ready !== exp_ir) $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ir);
    else n_pass++;
    n_checks++;
    if (out_valid !== exp_ov) $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_ov);
    else n_pass++;
    if (exp_ov) begin
      n_checks++;
      if (out_data !== exp_q[0]) $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_q[0]);
      else n_pass++;
    end
`ifdef DFF_PIPE_OCC_EN
    n_checks++;
    if (occ !== OW'(cnt)) $display("FAIL occ cyc=%0d got=%0d exp=%0d", cyc, occ, cnt);
    else n_pass++;
`endif
    seen_ir = in_ready;
    seen_ov = out_valid;
    seen_od = out_data;
    @(posedge clk);
    pop = e && !fl && exp_ov && ordy;
    acc = exp_ir && iv;
    if (fl) begin
      pos_q.delete();
      exp_q.delete();
    end else if (e) begin
      if (pop) begin
        void'(pos_q.pop_front());
        void'(exp_q.pop_front());
      end
      // Every word steps one slot forward unless the word ahead blocks it.
      lim = DEPTH - 1;
      foreach (pos_q[i]) begin
        np = pos_q[i] + 1;
        if (np > lim) np = lim;
        pos_q[i] = np;
        lim = np - 1;
      end
      if (acc) begin
        pos_q.push_back(0);
        exp_q.push_back(id);
      end
    end
    last_acc = acc;
    cyc++;
    #1;
  endtask

  // Idle input, downstream ready; record every word the DUT presents.
  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      do_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (seen_ov) got_q.push_back(seen_od);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #3;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++;
    if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
`ifdef DFF_PIPE_OCC_EN
    n_checks++;
    if (occ !== '0) $display("FAIL reset_occ got=%0d exp=0", occ); else n_pass++;
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pos_q.delete();
    exp_q.delete();
  endtask

  task automatic test_streaming;
    int first_acc, first_ov, last_ov, n_out, c;
    first_acc = -1; first_ov = -1; last_ov = -1; n_out = 0;
    got_q.delete();
    for (int i = 1; i <= 16; i++) begin
      c = cyc;
      if (i <= 10) do_cycle(1'b1, WIDTH'(i), 1'b1, 1'b1, 1'b0);
      else do_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (i <= 10 && seen_ir && first_acc < 0) first_acc = c;
      if (seen_ov) begin
        if (first_ov < 0) first_ov = c;
        last_ov = c;
        n_out++;
        got_q.push_back(seen_od);
      end
    end
    n_checks++;
    if (first_ov - first_acc !== 3) $display("FAIL stream_latency got=%0d exp=3", first_ov - first_acc); else n_pass++;
    n_checks++;
    if (n_out !== 10) $display("FAIL stream_count got=%0d exp=10", n_out); else n_pass++;
    n_checks++;
    if (last_ov - first_ov !== 9) $display("FAIL stream_rate got=%0d exp=9", last_ov - first_ov); else n_pass++;
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      n_checks++;
      if (got_q[i] !== WIDTH'(i + 1)) $display("FAIL stream_order idx=%0d got=%h exp=%h", i, got_q[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    int n_acc, k;
    logic [WIDTH-1:0] want [3];
    n_acc = 0; k = 1;
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, WIDTH'(k), 1'b0, 1'b1, 1'b0);
      if (seen_ir) begin
        n_acc++;
        k++;
      end
    end
    n_checks++;
    if (n_acc !== 3) $display("FAIL bp_accepts got=%0d exp=3", n_acc); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++;
    if (out_data !== 8'h01) $display("FAIL bp_hold got=%h exp=01", out_data); else n_pass++;
    got_q.delete();
    collect(6);
    want[0] = 8'h01; want[1] = 8'h02; want[2] = 8'h03;
    n_checks++;
    if (got_q.size() !== 3) $display("FAIL bp_drain_count got=%0d exp=3", got_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== want[i]) $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got_q[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_bubble;
    do_cycle(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (seen_ir !== 1'b1) $display("FAIL bubble_accept_bb got=%b exp=1", seen_ir); else n_pass++;
    // Two words held, one slot free, output stalled.
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bubble_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_checks++;
    if (out_data !== 8'hAA) $display("FAIL bubble_head got=%h exp=aa", out_data); else n_pass++;
`ifdef DFF_PIPE_OCC_EN
    n_checks++;
    if (occ !== OW'(2)) $display("FAIL bubble_occ got=%0d exp=2", occ); else n_pass++;
`endif
    got_q.delete();
    collect(5);
    n_checks++;
    if (got_q.size() !== 2 || got_q[0] !== 8'hAA || got_q[1] !== 8'hBB)
      $display("FAIL bubble_drain got_n=%0d exp=2 (aa,bb)", got_q.size());
    else n_pass++;
  endtask

  task automatic test_stall;
    do_cycle(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'h5B, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'h5C, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (seen_ir !== 1'b0) $display("FAIL stall_in_ready i=%0d got=%b exp=0", i, seen_ir); else n_pass++;
      n_checks++;
      if (seen_ov !== 1'b1 || seen_od !== 8'h5A)
        $display("FAIL stall_hold i=%0d got=%b/%h exp=1/5a", i, seen_ov, seen_od);
      else n_pass++;
    end
    got_q.delete();
    collect(6);
    n_checks++;
    if (got_q.size() !== 3 || got_q[0] !== 8'h5A || got_q[1] !== 8'h5B || got_q[2] !== 8'h5C)
      $display("FAIL stall_resume got_n=%0d exp=3 (5a,5b,5c)", got_q.size());
    else n_pass++;
  endtask

  task automatic test_flush;
    do_cycle(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'hC2, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (seen_ir !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", seen_ir); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++;
    if (out_data !== 8'h00) $display("FAIL flush_out_data got=%h exp=00", out_data); else n_pass++;
`ifdef DFF_PIPE_OCC_EN
    n_checks++;
    if (occ !== '0) $display("FAIL flush_occ got=%0d exp=0", occ); else n_pass++;
`endif
    got_q.delete();
    collect(5);
    n_checks++;
    if (got_q.size() !== 0) $display("FAIL flush_leak got_n=%0d exp=0", got_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL rmid_pre_valid got=%b exp=1", out_valid); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++;
    if (out_data !== 8'h00) $display("FAIL rmid_out_data got=%h exp=00", out_data); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL rmid_in_ready got=%b exp=0", in_ready); else n_pass++;
`ifdef DFF_PIPE_OCC_EN
    n_checks++;
    if (occ !== '0) $display("FAIL rmid_occ got=%0d exp=0", occ); else n_pass++;
`endif
    pos_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    got_q.delete();
    collect(4);
    n_checks++;
    if (got_q.size() !== 0) $display("FAIL rmid_leak got_n=%0d exp=0", got_q.size()); else n_pass++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 255)),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 39) == 0));
    end
    got_q.delete();
    collect(2 * DEPTH + 2);
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL random_drain out_valid=%b model_left=%0d exp=0/0", out_valid, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    test_back_to_back_full();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Full pipe with a pop and a push in the same cycle: occupancy stays 3.
  task automatic test_back_to_back_full;
    do_cycle(1'b1, 8'hD1, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'hD2, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'hD3, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 8'hD4, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (seen_ir !== 1'b1 || seen_od !== 8'hD1)
      $display("FAIL full_pushpop got=%b/%h exp=1/d1", seen_ir, seen_od);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hD2)
      $display("FAIL full_next got=%b/%h exp=1/d2", out_valid, out_data);
    else n_pass++;
    got_q.delete();
    collect(6);
    n_checks++;
    if (got_q.size() !== 3 || got_q[2] !== 8'hD4)
      $display("FAIL full_drain got_n=%0d exp=3", got_q.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
